mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for a single-port unified memory shared by the pipeline's instruction-fetch port (IF) and data-access port (DM). Serialises one access at a time, drives the memory's enable/write/address/data lines, and returns read data with a one-cycle acknowledge pulse. Dropping an in-flight fetch on branch/jump redirect is supported via a cancel input. Sits between the IF/MEM stages of the core and the memory macro; the core stalls a stage while its request is pending.

## Interface
- LAT, 2, memory read latency in cycles from the `mem_en` cycle to the cycle `mem_rdata` is valid; legal range 1..7.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held high with `if_addr` stable until `if_ack` or `if_cancel`.
- if_addr  in  ADDR_W  fetch address.
- if_cancel  in  1  discard the current or pending fetch.
- if_ack  out  1  one-cycle pulse; `if_rdata` is valid.
- if_rdata  out  DATA_W  fetched word; holds until the next `if_ack`.
- dm_req  in  1  data request; held high with `dm_addr`, `dm_we` and `dm_wdata` stable until `dm_ack`.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_ack  out  1  one-cycle pulse; access complete, `dm_rdata` valid for reads.
- dm_rdata  out  DATA_W  read word; holds until the next `dm_ack` of a read.
- mem_en  out  1  memory access strobe, high for exactly one cycle per access.
- mem_we  out  1  write strobe; high only when `mem_en` is high.
- mem_addr  out  ADDR_W  registered access address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.
- grant_dm  out  1  high when DM owns the current access; 0 in IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - Samples the requests. An IF request is eligible only when `if_req & ~if_cancel`.
  - If only one port is eligible, that port wins.
  - If both are eligible, the port not granted last time wins. The last-grant register resets to IF, so DM wins the first tie.
  - The winner's address, write enable and write data are latched. The state moves to ISSUE and the last-grant register is updated.
- **ISSUE**
  - Drives `mem_en`=1 for one cycle, with `mem_we` = latched `we` (always 0 for IF).
  - Loads the latency counter with LAT-1, then moves to WAIT.
- **WAIT**
  - Decrements the counter each cycle.
  - When the counter reaches 0, captures `mem_rdata` into the owner's rdata register (not for DM writes) and moves to RESP.
  - With LAT=1, WAIT lasts one cycle.
- **RESP**
  - Pulses the owner's ack, except when the owner is IF and the drop flag is set. In that case `if_ack` stays 0, `if_rdata` is left unchanged, and the drop flag clears.
  - Requests are not sampled in RESP. The state always returns to IDLE.
- **Cancel**
  - The drop flag is set when `if_cancel`=1 during ISSUE or WAIT while IF is the owner.
  - `if_cancel` during RESP has no effect, because the ack is already committed.
  - A cancelled fetch still completes on the memory side and still counts as IF's grant for fairness.
- A DM access is never cancelled. `mem_en`/`mem_we` are never suppressed once in ISSUE.

## Timing
- Request seen in IDLE at cycle t:
  - `mem_en` is high in cycle t+1.
  - `mem_rdata` is sampled at the end of cycle t+1+LAT.
  - The ack is high in cycle t+2+LAT.
- The next grant is possible in cycle t+3+LAT. Peak throughput is one access per LAT+3 cycles.
- Reads and writes have identical latency.
- **Reset** (asynchronous, active-low) values:
  - State is IDLE.
  - `if_ack`, `dm_ack`, `mem_en`, `mem_we`, `busy` and `grant_dm` are 0.
  - `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` are 0.
  - The drop flag and counter are 0; the last-grant register is IF.
- **Reset mid-access:** the access is abandoned and no ack is issued. A write already strobed may have completed in memory.
- **Request dropped early:** a requester deasserting `req` before its ack is a protocol violation, except IF via `if_cancel`. The arbiter still completes the access.

## Test plan
- **Single fetch, LAT=2:** `if_req`, `if_addr`=0x10 at cycle 0, memory returns 0x00000013. Required: `mem_en` high at cycle 1 with `mem_addr`=0x10 and `mem_we`=0; `if_ack` at cycle 4; `if_rdata`=0x13; `busy` high cycles 1–4.
- **DM write then read, LAT=2:** write 0xDEADBEEF to 0x100. Required: `mem_we`=1 with `mem_wdata`=0xDEADBEEF in the `mem_en` cycle, then `dm_ack`. A following read of 0x100 returns 0xDEADBEEF, and `dm_rdata` is unchanged by the write.
- **Simultaneous requests from reset:** `if_req` and `dm_req` held continuously. Required: grants alternate DM, IF, DM, IF. `grant_dm` is 1,0,1,0 per access, and acks are spaced 5 cycles apart (LAT=2).
- **Cancel in WAIT:** pulse `if_cancel` at cycle 2 of an IF fetch. Required: `mem_en` still fires at cycle 1; no `if_ack`; `if_rdata` holds its old value; the pending `dm_req` is granted in cycle 5.
- **Cancel in IDLE:** `if_req` and `if_cancel` together in IDLE with `dm_req`=0. Required: no grant, and `busy` stays 0.
- **Reset mid-access and LAT sweep:** assert `reset`=0 during WAIT. Required: all outputs 0 immediately and no ack after release. Repeat the single-fetch case with LAT=1 and LAT=7; the ack must land at cycle LAT+2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for a single-port memory shared by instruction fetch (IF) and data (DM).
// Serialises one access at a time; an in-flight fetch can be dropped with if_cancel.
module mem_arbiter #(
   parameter int unsigned LAT    = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_dm
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q;
   logic [2:0]        cnt_q;
   logic              last_dm_q;
   logic              drop_q;
   logic              we_q;
   logic              if_ack_q, dm_ack_q, mem_en_q, mem_we_q, busy_q, grant_dm_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

   logic if_elig, pick_dm, cancel_own;

   assign if_elig    = if_req & ~if_cancel;
   // On a tie the port not granted last time wins.
   assign pick_dm    = dm_req & (~if_elig | ~last_dm_q);
   assign cancel_own = if_cancel & ~grant_dm_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         last_dm_q   <= 1'b0;
         drop_q      <= 1'b0;
         we_q        <= 1'b0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         grant_dm_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (if_elig || dm_req) begin
                  state_q    <= StIssue;
                  busy_q     <= 1'b1;
                  mem_en_q   <= 1'b1;
                  grant_dm_q <= pick_dm;
                  last_dm_q  <= pick_dm;
                  drop_q     <= 1'b0;
                  if (pick_dm) begin
                     mem_addr_q  <= dm_addr;
                     mem_wdata_q <= dm_wdata;
                     mem_we_q    <= dm_we;
                     we_q        <= dm_we;
                  end else begin
                     mem_addr_q <= if_addr;
                     we_q       <= 1'b0;
                  end
               end
            end
            StIssue: begin
               cnt_q   <= 3'(LAT - 1);
               state_q <= StWait;
               if (cancel_own) drop_q <= 1'b1;
            end
            StWait: begin
               if (cancel_own) drop_q <= 1'b1;
               if (cnt_q == 3'd0) begin
                  state_q <= StResp;
                  if (grant_dm_q) begin
                     dm_ack_q <= 1'b1;
                     if (!we_q) dm_rdata_q <= mem_rdata;
                  end else if (!(drop_q || if_cancel)) begin
                     // A cancel in the final wait cycle still drops the fetch.
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            StResp: begin
               state_q    <= StIdle;
               busy_q     <= 1'b0;
               grant_dm_q <= 1'b0;
               drop_q     <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign if_ack    = if_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_ack    = dm_ack_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-timing model, directed scenarios,
// a LAT=1/LAT=7 latency sweep and randomized traffic.
module tb_mem_arbiter;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0, if_cancel = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
   logic        if_ack, dm_ack, mem_en, mem_we, busy, grant_dm;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

   // Latency-sweep instances (index 0: LAT=1, index 1: LAT=7)
   logic        s_req [2];
   logic [31:0] s_rd [2];
   logic        s_ack [2], s_dmack [2], s_en [2], s_we [2], s_busy [2], s_gdm [2];
   logic [31:0] s_ifrd [2], s_dmrd [2], s_maddr [2], s_mwd [2];
   logic [31:0] s_fetch_addr = 32'h10;
   logic [31:0] zero32 = '0;
   logic        zero1 = 1'b0;

   mem_arbiter #(.LAT(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .grant_dm(grant_dm)
   );

   mem_arbiter #(.LAT(1), .ADDR_W(32), .DATA_W(32)) u_lat1 (
      .clk(clk), .reset(reset),
      .if_req(s_req[0]), .if_addr(s_fetch_addr), .if_cancel(zero1),
      .if_ack(s_ack[0]), .if_rdata(s_ifrd[0]),
      .dm_req(zero1), .dm_we(zero1), .dm_addr(zero32), .dm_wdata(zero32),
      .dm_ack(s_dmack[0]), .dm_rdata(s_dmrd[0]),
      .mem_en(s_en[0]), .mem_we(s_we[0]), .mem_addr(s_maddr[0]), .mem_wdata(s_mwd[0]),
      .mem_rdata(s_rd[0]), .busy(s_busy[0]), .grant_dm(s_gdm[0])
   );

   mem_arbiter #(.LAT(7), .ADDR_W(32), .DATA_W(32)) u_lat7 (
      .clk(clk), .reset(reset),
      .if_req(s_req[1]), .if_addr(s_fetch_addr), .if_cancel(zero1),
      .if_ack(s_ack[1]), .if_rdata(s_ifrd[1]),
      .dm_req(zero1), .dm_we(zero1), .dm_addr(zero32), .dm_wdata(zero32),
      .dm_ack(s_dmack[1]), .dm_rdata(s_dmrd[1]),
      .mem_en(s_en[1]), .mem_we(s_we[1]), .mem_addr(s_maddr[1]), .mem_wdata(s_mwd[1]),
      .mem_rdata(s_rd[1]), .busy(s_busy[1]), .grant_dm(s_gdm[1])
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   // Model: one outstanding transaction, timed relative to its grant cycle
   logic        m_act = 1'b0, m_dm = 1'b0, m_we = 1'b0, m_drop = 1'b0, m_last_dm = 1'b0;
   int          m_t = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
   logic [31:0] ref_mem [16];

   // Memory environment driven by what the DUT actually strobes
   logic [31:0] env_mem [16];
   logic        rd_pend = 1'b0;
   int          rd_cyc = 0;
   logic [31:0] rd_addr = '0;

   // Observations of the DUT for the hand-computed scenario checks
   int   obs_en_cyc = 0, obs_ifack_cyc = 0, obs_dmack_cyc = 0;
   int   n_en = 0, n_ifack = 0, n_busy = 0;
   logic obs_we = 1'b0;
   logic [31:0] obs_addr = '0, obs_wdata = '0;
   int   obs_en_q [$];
   logic obs_gnt_q [$];
   int   obs_ack_q [$];
   logic p_ifack = 1'b0, p_dmack = 1'b0;

   function automatic int ix(input logic [31:0] a);
      return int'(a[5:2]);
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle: check outputs, run the memory, apply inputs, advance the model.
   task automatic tick(input logic ifr, input logic [31:0] ifa, input logic ifc,
                       input logic dmr, input logic dmwe, input logic [31:0] dma,
                       input logic [31:0] dmwd);
      int   k;
      logic e_en, e_ifack, e_dmack, idle_now, if_el, pdm;
      @(negedge clk);
      k       = cyc - m_t;
      e_en    = m_act && k == 1;
      e_ifack = m_act && k == int'(LAT) + 2 && !m_dm && !m_drop;
      e_dmack = m_act && k == int'(LAT) + 2 && m_dm;
      if (e_ifack) m_if_rdata = ref_mem[ix(m_addr)];
      if (e_dmack && !m_we) m_dm_rdata = ref_mem[ix(m_addr)];
      chk1("busy", busy, m_act);
      chk1("mem_en", mem_en, e_en);
      chk1("mem_we", mem_we, e_en && m_we);
      chk1("grant_dm", grant_dm, m_act && m_dm);
      chk1("if_ack", if_ack, e_ifack);
      chk1("dm_ack", dm_ack, e_dmack);
      chk32("if_rdata", if_rdata, m_if_rdata);
      chk32("dm_rdata", dm_rdata, m_dm_rdata);
      if (e_en) chk32("mem_addr", mem_addr, m_addr);
      if (e_en && m_we) chk32("mem_wdata", mem_wdata, m_wdata);

      if (mem_en) begin
         obs_en_cyc = cyc; obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
         obs_en_q.push_back(cyc); obs_gnt_q.push_back(grant_dm); n_en++;
         if (mem_we) env_mem[ix(mem_addr)] = mem_wdata;
         else begin rd_pend = 1'b1; rd_cyc = cyc + int'(LAT); rd_addr = mem_addr; end
      end
      if (if_ack) begin obs_ifack_cyc = cyc; n_ifack++; obs_ack_q.push_back(cyc); end
      if (dm_ack) begin obs_dmack_cyc = cyc; obs_ack_q.push_back(cyc); end
      if (busy) n_busy++;

      if_req = ifr; if_addr = ifa; if_cancel = ifc;
      dm_req = dmr; dm_we = dmwe; dm_addr = dma; dm_wdata = dmwd;

      idle_now = !m_act;
      if (m_act) begin
         if (!m_dm && ifc && k >= 1 && k <= int'(LAT) + 1) m_drop = 1'b1;
         if (k == int'(LAT) + 2) m_act = 1'b0;
      end
      if (idle_now) begin
         if_el = ifr && !ifc;
         if (if_el || dmr) begin
            pdm = dmr && (!if_el || !m_last_dm);
            m_act = 1'b1; m_t = cyc; m_dm = pdm; m_last_dm = pdm; m_drop = 1'b0;
            m_addr = pdm ? dma : ifa; m_we = pdm && dmwe; m_wdata = dmwd;
            if (m_we) ref_mem[ix(dma)] = dmwd;
         end
      end

      if (rd_pend && rd_cyc == cyc) begin
         mem_rdata = env_mem[ix(rd_addr)];
         rd_pend = 1'b0;
      end else begin
         mem_rdata = $urandom;
      end
      p_ifack = e_ifack;
      p_dmack = e_dmack;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      if_req = 1'b0; if_cancel = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      reset = 1'b0;
      #1;
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_dm_ack", dm_ack, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_grant_dm", grant_dm, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      chk32("rst_if_rdata", if_rdata, 32'h0);
      chk32("rst_dm_rdata", dm_rdata, 32'h0);
      #2;
      reset = 1'b1;
      m_act = 1'b0; m_drop = 1'b0; m_last_dm = 1'b0; m_if_rdata = '0; m_dm_rdata = '0;
      rd_pend = 1'b0;
   endtask

   task automatic lat_sweep();
      int L;
      for (int r = 0; r <= 12; r++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            L = (i == 0) ? 1 : 7;
            chk1(i == 0 ? "lat1_mem_en" : "lat7_mem_en", s_en[i], r == 1);
            chk1(i == 0 ? "lat1_if_ack" : "lat7_if_ack", s_ack[i], r == L + 2);
            chk1(i == 0 ? "lat1_busy" : "lat7_busy", s_busy[i], r >= 1 && r <= L + 2);
            chk1(i == 0 ? "lat1_dm_side" : "lat7_dm_side", s_dmack[i] | s_gdm[i] | s_we[i],
                 1'b0);
            if (s_en[i]) chk32(i == 0 ? "lat1_addr" : "lat7_addr", s_maddr[i], 32'h10);
            if (r == L + 2) chk32(i == 0 ? "lat1_rdata" : "lat7_rdata", s_ifrd[i], 32'h13);
            s_req[i] = (r < L + 2);
            s_rd[i]  = (r == L + 1) ? 32'h13 : $urandom;
         end
      end
      for (int i = 0; i < 2; i++) chk32("lat_unused_regs", s_dmrd[i] | s_mwd[i], 32'h0);
   endtask

   initial begin
      int c0, b0, a0, e0;
      logic        if_pend, dm_pend, dwe, ifc;
      logic [31:0] ia, da, dwd;

      for (int i = 0; i < 16; i++) begin
         env_mem[i] = 32'hA5A5_0000 | 32'(i);
         ref_mem[i] = 32'hA5A5_0000 | 32'(i);
      end
      env_mem[4] = 32'h13;
      ref_mem[4] = 32'h13;
      for (int i = 0; i < 2; i++) begin s_req[i] = 1'b0; s_rd[i] = '0; end

      do_reset();

      // Both ports held from reset: DM, IF, DM, IF, acks 5 cycles apart
      obs_gnt_q.delete(); obs_ack_q.delete();
      for (int i = 0; i < 22; i++) tick(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h24, '0);
      chk_int("tie_grant_count", obs_gnt_q.size(), 5);
      chk_int("tie_ack_count", obs_ack_q.size(), 4);
      if (obs_gnt_q.size() >= 4 && obs_ack_q.size() >= 4) begin
         chk1("tie_grant0", obs_gnt_q[0], 1'b1);
         chk1("tie_grant1", obs_gnt_q[1], 1'b0);
         chk1("tie_grant2", obs_gnt_q[2], 1'b1);
         chk1("tie_grant3", obs_gnt_q[3], 1'b0);
         for (int i = 0; i < 3; i++) chk_int("tie_ack_spacing", obs_ack_q[i+1] - obs_ack_q[i], 5);
      end
      idle(6);

      // Single fetch of 0x10
      b0 = n_busy;
      tick(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, '0, '0);
      c0 = cyc;
      for (int i = 0; i < 4; i++) tick(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, '0, '0);
      idle(2);
      chk_int("fetch_mem_en_cycle", obs_en_cyc - c0, 1);
      chk32("fetch_mem_addr", obs_addr, 32'h10);
      chk1("fetch_mem_we", obs_we, 1'b0);
      chk_int("fetch_ack_cycle", obs_ifack_cyc - c0, 4);
      chk32("fetch_rdata", if_rdata, 32'h13);
      chk_int("fetch_busy_cycles", n_busy - b0, 4);

      // DM write then read of 0x100
      tick(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
      c0 = cyc;
      for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
      chk1("wr_mem_we", obs_we, 1'b1);
      chk32("wr_mem_wdata", obs_wdata, 32'hDEADBEEF);
      chk_int("wr_ack_cycle", obs_dmack_cyc - c0, 4);
      chk32("wr_keeps_dm_rdata", dm_rdata, 32'hA5A50009);
      idle(1);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h100, '0);
      c0 = cyc;
      for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h100, '0);
      chk_int("rd_ack_cycle", obs_dmack_cyc - c0, 4);
      chk32("rd_dm_rdata", dm_rdata, 32'hDEADBEEF);
      idle(1);

      // Cancel in WAIT with a DM request waiting behind the fetch
      obs_en_q.delete();
      a0 = n_ifack;
      tick(1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 32'h28, '0);
      c0 = cyc;
      tick(1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 32'h28, '0);
      tick(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 32'h28, '0);
      for (int i = 0; i < 7; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h28, '0);
      idle(1);
      chk_int("cancel_en_count", obs_en_q.size(), 2);
      if (obs_en_q.size() >= 2) begin
         chk_int("cancel_if_mem_en", obs_en_q[0] - c0, 1);
         chk_int("cancel_dm_mem_en", obs_en_q[1] - c0, 6);
      end
      chk_int("cancel_no_if_ack", n_ifack - a0, 0);
      chk32("cancel_if_rdata_held", if_rdata, 32'h13);
      chk_int("cancel_dm_ack_cycle", obs_dmack_cyc - c0, 9);

      // Cancel together with the request in IDLE: nothing is granted
      e0 = n_en; b0 = n_busy;
      tick(1'b1, 32'h34, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(3);
      chk_int("idle_cancel_no_grant", n_en - e0, 0);
      chk_int("idle_cancel_no_busy", n_busy - b0, 0);

      // Reset while the fetch is in WAIT
      a0 = n_ifack;
      for (int i = 0; i < 3; i++) tick(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, '0, '0);
      do_reset();
      idle(8);
      chk_int("reset_mid_no_ack", n_ifack - a0, 0);

      lat_sweep();

      // Randomized traffic
      if_pend = 1'b0; dm_pend = 1'b0; dwe = 1'b0; ia = '0; da = '0; dwd = '0;
      for (int n = 0; n < 3000; n++) begin
         if (p_ifack) if_pend = 1'b0;
         if (p_dmack) dm_pend = 1'b0;
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            ia = 32'($urandom_range(0, 15)) << 2;
         end
         if (!dm_pend && $urandom_range(0, 2) == 0) begin
            dm_pend = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            da  = 32'($urandom_range(0, 15)) << 2;
            dwd = $urandom;
         end
         ifc = ($urandom_range(0, 19) == 0);
         tick(if_pend, ia, ifc, dm_pend, dwe, da, dwd);
         if (ifc) if_pend = 1'b0;
      end
      idle(12);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
